// File: rtl/doomsday_timer.sv
// doomsday_timer: BCD MM:SS up/down timer with run/pause control, an internal
// one-second prescaler, load validation and expiry/rollover flags.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   clear      sync: digits 00:00, state IDLE, prescaler 0
//   load       sync: load load_mm/load_ss if valid, state IDLE, prescaler 0
//   load_mm    BCD minutes {tens, units}
//   load_ss    BCD seconds {tens, units}
//   run        level: 1 counts, 0 pauses
//   dir        0 = up, 1 = down, sampled on each tick
//   bin3..bin0 minutes tens, minutes units, seconds tens, seconds units
//   tick       one-cycle pulse per counted second
//   expired    one-cycle pulse on reaching 00:00 while counting down
//   rollover   one-cycle pulse on wrap/saturation at MIN_MAX:59
//   load_err   one-cycle pulse when a load is rejected
//   running    high in RUN
//   done       high in EXPIRED
module doomsday_timer #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MIN_MAX  = 59,
  parameter bit          WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       run,
  input  logic       dir,
  output logic [3:0] bin3,
  output logic [3:0] bin2,
  output logic [3:0] bin1,
  output logic [3:0] bin0,
  output logic       tick,
  output logic       expired,
  output logic       rollover,
  output logic       load_err,
  output logic       running,
  output logic       done
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MM_T     = 4'(MIN_MAX / 10);
  localparam logic [3:0]    MM_U     = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] pre_q, pre_n;
  logic [3:0]    d3_n, d2_n, d1_n, d0_n;
  logic          tick_n, exp_n, roll_n, lerr_n;
  logic          at_zero, at_one, at_top;

  // Minutes are compared digit-wise against MIN_MAX to avoid a multiplier.
  function automatic logic load_ok(input logic [7:0] mm, input logic [7:0] ss);
    logic nib_ok, ss_ok, mm_ok;
    nib_ok = (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
             (ss[7:4] <= 4'd9) && (ss[3:0] <= 4'd9);
    ss_ok  = (ss[7:4] <= 4'd5);
    mm_ok  = (mm[7:4] < MM_T) || ((mm[7:4] == MM_T) && (mm[3:0] <= MM_U));
    return nib_ok && ss_ok && mm_ok;
  endfunction

  always_comb begin
    state_n = state_q;
    pre_n   = pre_q;
    d3_n    = bin3;
    d2_n    = bin2;
    d1_n    = bin1;
    d0_n    = bin0;
    tick_n  = 1'b0;
    exp_n   = 1'b0;
    roll_n  = 1'b0;
    lerr_n  = 1'b0;

    at_zero = (bin3 == 4'd0) && (bin2 == 4'd0) && (bin1 == 4'd0) && (bin0 == 4'd0);
    at_one  = (bin3 == 4'd0) && (bin2 == 4'd0) && (bin1 == 4'd0) && (bin0 == 4'd1);
    at_top  = (bin3 == MM_T) && (bin2 == MM_U) && (bin1 == 4'd5) && (bin0 == 4'd9);

    if (clear) begin
      state_n = S_IDLE;
      pre_n   = '0;
      d3_n    = '0;
      d2_n    = '0;
      d1_n    = '0;
      d0_n    = '0;
    end else if (load) begin
      state_n = S_IDLE;
      pre_n   = '0;
      if (load_ok(load_mm, load_ss)) begin
        d3_n = load_mm[7:4];
        d2_n = load_mm[3:0];
        d1_n = load_ss[7:4];
        d0_n = load_ss[3:0];
      end else begin
        lerr_n = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run && !(dir && at_zero)) state_n = S_RUN;
        end
        S_RUN: begin
          // Pausing leaves the prescaler untouched so the partial second survives.
          if (!run) begin
            state_n = S_IDLE;
          end else if (pre_q != PRE_LAST) begin
            pre_n = pre_q + 1'b1;
          end else begin
            pre_n  = '0;
            tick_n = 1'b1;
            if (!dir) begin
              if (at_top) begin
                roll_n = 1'b1;
                if (WRAP) begin
                  d3_n = '0;
                  d2_n = '0;
                  d1_n = '0;
                  d0_n = '0;
                end else begin
                  state_n = S_IDLE;
                end
              end else if (bin0 != 4'd9) begin
                d0_n = bin0 + 4'd1;
              end else begin
                d0_n = '0;
                if (bin1 != 4'd5) begin
                  d1_n = bin1 + 4'd1;
                end else begin
                  d1_n = '0;
                  if (bin2 != 4'd9) begin
                    d2_n = bin2 + 4'd1;
                  end else begin
                    d2_n = '0;
                    d3_n = bin3 + 4'd1;
                  end
                end
              end
            end else begin
              // 00:00 can be reached in RUN via an up-wrap; a down tick there expires at once.
              if (at_zero || at_one) begin
                d3_n    = '0;
                d2_n    = '0;
                d1_n    = '0;
                d0_n    = '0;
                exp_n   = 1'b1;
                state_n = S_EXPIRED;
              end else if (bin0 != 4'd0) begin
                d0_n = bin0 - 4'd1;
              end else begin
                d0_n = 4'd9;
                if (bin1 != 4'd0) begin
                  d1_n = bin1 - 4'd1;
                end else begin
                  d1_n = 4'd5;
                  if (bin2 != 4'd0) begin
                    d2_n = bin2 - 4'd1;
                  end else begin
                    d2_n = 4'd9;
                    d3_n = bin3 - 4'd1;
                  end
                end
              end
            end
          end
        end
        S_EXPIRED: begin
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      bin3     <= '0;
      bin2     <= '0;
      bin1     <= '0;
      bin0     <= '0;
      tick     <= 1'b0;
      expired  <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      pre_q    <= pre_n;
      bin3     <= d3_n;
      bin2     <= d2_n;
      bin1     <= d1_n;
      bin0     <= d0_n;
      tick     <= tick_n;
      expired  <= exp_n;
      rollover <= roll_n;
      load_err <= lerr_n;
      running  <= (state_n == S_RUN);
      done     <= (state_n == S_EXPIRED);
    end
  end

endmodule

// File: doc/doomsday_timer.md
# doomsday_timer

Parametrised BCD MM:SS timer, the successor to the free-running display counter. It counts up or down from a loadable value with run/pause control. Down-counts stop and flag expiry at 00:00. Up-counts wrap or saturate at a programmable minute limit. It drives `bin3..bin0` into the existing `SegDisplay` multiplexer and generates its own tick from `clk` through an internal prescaler.

## Interface
- `TICK_DIV`, default 100000000, `clk` cycles per one-second tick (≥2).
- `MIN_MAX`, default 59, highest minutes value (1..99). Seconds always run 00..59.
- `WRAP`, default 1, up-count behaviour at `MIN_MAX:59`: 1 wraps to 00:00, 0 saturates and stops.

Ports:
- `clk` in 1, system clock; all logic on posedge.
- `reset_n` in 1, asynchronous, active-low reset.
- `clear` in 1, synchronous: digits to 00:00, state IDLE, prescaler to 0.
- `load` in 1, synchronous: load `load_mm`/`load_ss`, state IDLE, prescaler to 0.
- `load_mm` in 8, BCD minutes, {tens, units}.
- `load_ss` in 8, BCD seconds, {tens, units}.
- `run` in 1, level: 1 counts, 0 pauses.
- `dir` in 1, 0 = up, 1 = down; sampled on every tick.
- `bin3` out 4, minutes tens (BCD).
- `bin2` out 4, minutes units.
- `bin1` out 4, seconds tens.
- `bin0` out 4, seconds units.
- `tick` out 1, one-cycle pulse on each counted second.
- `expired` out 1, one-cycle pulse on reaching 00:00 while counting down.
- `rollover` out 1, one-cycle pulse on wrap or saturation at `MIN_MAX:59`.
- `load_err` out 1, one-cycle pulse when a load is rejected.
- `running` out 1, high in state RUN.
- `done` out 1, high in state EXPIRED.

## Operation
- States: IDLE, RUN, EXPIRED.
- Reset: state IDLE; digits 0; prescaler 0; all pulse outputs, `running` and `done` all 0.
- Priority each cycle: `clear` > `load` > run/tick logic.
- Load validation: every nibble must be ≤9, `load_ss` ≤59, `load_mm` ≤ `MIN_MAX`.
  - Valid: digits take the load values.
  - Invalid: digits unchanged, `load_err` pulses.
  - Either way: state goes to IDLE and prescaler to 0.
- IDLE → RUN when `run`=1, except when `dir`=1 and digits are 00:00; then the block stays in IDLE with no pulse.
- RUN → IDLE when `run`=0. The prescaler holds its value, so a pause preserves the partial second.
- RUN: the prescaler counts 0..`TICK_DIV`-1. On the wrap cycle the time steps by one second and `tick` pulses.
- Up step:
  - `bin0` 9 carries into `bin1`; `bin1` 5 carries into minutes.
  - Minutes increment in BCD.
  - At `MIN_MAX:59`: with `WRAP`=1, go to 00:00, pulse `rollover`, stay in RUN. With `WRAP`=0, hold `MIN_MAX:59`, pulse `rollover`, go to IDLE.
- Down step: BCD borrow, with seconds 00 → 59 and a borrow from minutes. Reaching 00:00 pulses `expired` and moves to EXPIRED.
- EXPIRED: digits frozen at 00:00 and `done`=1. The block leaves EXPIRED only on `clear` or `load`; `run` is ignored.
- A `dir` change mid-run takes effect at the next tick. The prescaler is not reset.
- Digits never leave 00:00..`MIN_MAX`:59 and every nibble stays ≤9.

## Timing
- All outputs are registered.
- Digits, `tick`, `expired` and `rollover` update on the same edge as the prescaler wrap. The pulses are high for exactly one cycle.
- From IDLE with prescaler 0 and `run` rising: state is RUN on the next edge, and the first `tick` comes `TICK_DIV` cycles after RUN is entered.
- Load/clear: digits, state and `load_err` valid one cycle after the request.
- A tick coinciding with `load` or `clear` is discarded and produces no pulse.
- Asserting `reset_n` mid-count clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset then `run`=1, `dir`=0, `TICK_DIV`=4:
  - `tick` fires every 4 cycles.
  - After 10 ticks the digits read 00:10.
  - After 60 ticks they read 01:00.
- `MIN_MAX`=2, `WRAP`=1, load 02:58, count up:
  - 02:59 is reached, then 00:00 with `rollover`=1 for one cycle, and counting continues.
- `WRAP`=0, same load 02:58, count up:
  - The timer holds at 02:59 with `rollover` pulsed, and `running` drops to 0.
- Load 00:02 with `dir`=1, then run:
  - The count goes 00:01, then 00:00 with `expired` pulsed and `done`=1.
  - Further `run` has no effect; `clear` returns to IDLE.
- Load 07:30, then load 0x6A / 0x00, then load 01:75:
  - The first load is accepted.
  - The second and third are rejected with `load_err` pulsed, and the digits stay 07:30.
- Pause and reset:
  - `run` dropped 2 cycles into a second and raised later → the next tick arrives 2 cycles after resumption.
  - `reset_n` low mid-count → outputs go to 0 asynchronously.
